// File: rtl/knn_pkg.sv
// knn_pkg: shared state encoding, default geometry and distance-width helper
// for the k-nearest-neighbour selector.
package knn_pkg;

    localparam int KNN_WDATA_W_DEF = 16;
    localparam int K_DEF           = 4;
    localparam int LABEL_W_DEF     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COUNT,
        ST_ARGMAX,
        ST_DONE
    } knn_state_e;

    // Squared distances need twice the coordinate width.
    function automatic int knn_dist_w(input int wdata_w);
        return 2 * wdata_w;
    endfunction

    localparam int KNN_DIST_W_DEF = knn_dist_w(KNN_WDATA_W_DEF);

endpackage

// File: rtl/knn_vote.sv
// knn_vote: per-class vote counters plus a serial argmax scan.
// The scan is driven from the highest label down with >=, so on equal
// counts the lower label replaces the earlier winner.
module knn_vote
    import knn_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int LABEL_W = LABEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               cnt_en,
    input  logic [LABEL_W-1:0] cnt_label,
    input  logic               scan_en,
    input  logic [LABEL_W-1:0] scan_label,
    input  logic               latch,
    output logic [LABEL_W-1:0] result_label
);

    localparam int NCLASS = 2 ** LABEL_W;
    localparam int CW     = $clog2(K + 1);

    logic [CW-1:0]      votes [NCLASS];
    logic [CW-1:0]      best_cnt;
    logic [LABEL_W-1:0] best_label;

    // Vote accumulation, argmax scan and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCLASS; c++) votes[c] <= '0;
            best_cnt     <= '0;
            best_label   <= '0;
            result_label <= '0;
        end else if (clr) begin
            for (int c = 0; c < NCLASS; c++) votes[c] <= '0;
            best_cnt     <= '0;
            best_label   <= '0;
            result_label <= '0;
        end else begin
            if (cnt_en)
                votes[cnt_label] <= votes[cnt_label] + CW'(1);
            if (scan_en && (votes[scan_label] >= best_cnt)) begin
                best_cnt   <= votes[scan_label];
                best_label <= scan_label;
            end
            if (latch)
                result_label <= best_label;
        end
    end

endmodule

// File: rtl/knn_select.sv
// knn_select: keeps the K smallest squared distances in a sorted list and
// reports the majority class among them.
// Optional feature: define KNN_SELECT_DIST_OUT_EN to add the nearest_d2 output.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | after reset, waiting for start
//   ST_COLLECT | accepting samples, inserting into the sorted list
//   ST_COUNT   | one list entry per cycle fed to the vote counters
//   ST_ARGMAX  | one class per cycle scanned, then one cycle to latch winner
//   ST_DONE    | result valid, held until the next start
module knn_select
    import knn_pkg::*;
#(
    parameter int KNN_WDATA_W = KNN_WDATA_W_DEF,
    parameter int K           = K_DEF,
    parameter int LABEL_W     = LABEL_W_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               d2_valid,
    input  logic [knn_dist_w(KNN_WDATA_W)-1:0] d2,
    input  logic [LABEL_W-1:0]                 label,
    input  logic                               d2_last,
    output logic                               d2_ready,
    output logic                               busy,
    output logic                               result_valid,
    output logic [LABEL_W-1:0]                 result_label,
    output logic [$clog2(K+1)-1:0]             n_valid
`ifdef KNN_SELECT_DIST_OUT_EN
   ,output logic [knn_dist_w(KNN_WDATA_W)-1:0] nearest_d2
`endif
);

    localparam int DIST_W   = knn_dist_w(KNN_WDATA_W);
    localparam int NCLASS   = 2 ** LABEL_W;
    localparam int NW       = $clog2(K + 1);
    localparam int STEP_MAX = (K - 1 > NCLASS) ? K - 1 : NCLASS;
    localparam int SW       = $clog2(STEP_MAX + 1);

    knn_state_e state, state_nxt;

    logic [DIST_W-1:0]  ent_d [K];
    logic [LABEL_W-1:0] ent_l [K];
    logic [K-1:0]       ent_v;
    logic [DIST_W-1:0]  sh_d  [K];
    logic [LABEL_W-1:0] sh_l  [K];
    logic [K-1:0]       sh_v;
    logic [K-1:0]       take;
    logic [K-1:0]       ins;
    logic [SW-1:0]      step;
    logic               accept;
    logic               sel_v;
    logic [LABEL_W-1:0] sel_l;
    logic               vote_cnt_en;
    logic               vote_scan_en;
    logic               vote_latch;

    // start has priority: a beat offered in the same cycle is dropped.
    assign accept = (state == ST_COLLECT) && d2_valid && !start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start restarts from any state.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: if (accept && d2_last) state_nxt = ST_COUNT;
                ST_COUNT:   if (step == '0)        state_nxt = ST_ARGMAX;
                ST_ARGMAX:  if (step == '0)        state_nxt = ST_DONE;
                default:    state_nxt = state;
            endcase
        end
    end

    // Outputs decoded from state.
    always_comb begin
        d2_ready     = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state)
            ST_COLLECT: begin
                d2_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_COUNT, ST_ARGMAX: busy = 1'b1;
            ST_DONE:             result_valid = 1'b1;
            default: ;
        endcase
    end

    // Phase down-counter: K-1..0 through COUNT, NCLASS..0 through ARGMAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            step <= '0;
        else if (accept && d2_last)
            step <= SW'(K - 1);
        else if ((state == ST_COUNT) && (step == '0))
            step <= SW'(NCLASS);
        else if (((state == ST_COUNT) || (state == ST_ARGMAX)) && (step != '0))
            step <= step - SW'(1);
    end

    // Insertion point: first slot that is empty or holds a strictly larger
    // distance, so equal distances keep arrival order.
    always_comb begin
        for (int i = 0; i < K; i++)
            take[i] = !ent_v[i] || (ent_d[i] > d2);
        ins[0] = take[0];
        for (int i = 1; i < K; i++)
            ins[i] = take[i] && !take[i-1];
    end

    // List shifted down by one slot, used for entries behind the new sample.
    always_comb begin
        sh_d[0] = '0;
        sh_l[0] = '0;
        sh_v[0] = 1'b0;
        for (int i = 1; i < K; i++) begin
            sh_d[i] = ent_d[i-1];
            sh_l[i] = ent_l[i-1];
            sh_v[i] = ent_v[i-1];
        end
    end

    // Sorted neighbour list; a full list with no insertion point discards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v <= '0;
            for (int i = 0; i < K; i++) begin
                ent_d[i] <= '0;
                ent_l[i] <= '0;
            end
        end else if (start) begin
            ent_v <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++) begin
                if (ins[i]) begin
                    ent_d[i] <= d2;
                    ent_l[i] <= label;
                    ent_v[i] <= 1'b1;
                end else if (take[i]) begin
                    ent_d[i] <= sh_d[i];
                    ent_l[i] <= sh_l[i];
                    ent_v[i] <= sh_v[i];
                end
            end
        end
    end

    // Occupancy counter, saturating naturally at K.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            n_valid <= '0;
        else if (start)
            n_valid <= '0;
        else if (accept && !ent_v[K-1])
            n_valid <= n_valid + NW'(1);
    end

    // Entry currently addressed by the COUNT phase.
    always_comb begin
        sel_v = 1'b0;
        sel_l = '0;
        for (int i = 0; i < K; i++) begin
            if (step == SW'(i)) begin
                sel_v = ent_v[i];
                sel_l = ent_l[i];
            end
        end
    end

    assign vote_cnt_en  = (state == ST_COUNT)  && !start && sel_v;
    assign vote_scan_en = (state == ST_ARGMAX) && !start && (step != '0);
    assign vote_latch   = (state == ST_ARGMAX) && !start && (step == '0);

    knn_vote #(
        .K       (K),
        .LABEL_W (LABEL_W)
    ) u_vote (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (start),
        .cnt_en       (vote_cnt_en),
        .cnt_label    (sel_l),
        .scan_en      (vote_scan_en),
        .scan_label   (LABEL_W'(step - SW'(1))),
        .latch        (vote_latch),
        .result_label (result_label)
    );

`ifdef KNN_SELECT_DIST_OUT_EN
    // Nearest distance captured alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nearest_d2 <= '0;
        else if (start)
            nearest_d2 <= '0;
        else if (vote_latch)
            nearest_d2 <= ent_v[0] ? ent_d[0] : '0;
    end
`endif

endmodule
